// File: rtl/pe_pkg.sv
// Arithmetic helpers for the pe_vec dot-product tile: accumulator range limits, clamping and lane offsets.
// Everything is evaluated in a wide signed container so any legal accumulator width and signedness fits.
package pe_pkg;

  localparam int unsigned CALC_W = 66;
  typedef logic signed [CALC_W-1:0] calc_t;

  function automatic calc_t acc_max(int unsigned w, bit sgn);
    calc_t one;
    one = calc_t'(1);
    return sgn ? (one << (w - 1)) - one : (one << w) - one;
  endfunction

  function automatic calc_t acc_min(int unsigned w, bit sgn);
    calc_t one;
    one = calc_t'(1);
    return sgn ? -(one << (w - 1)) : calc_t'(0);
  endfunction

  function automatic bit acc_ovf(calc_t v, int unsigned w, bit sgn);
    return (v > acc_max(w, sgn)) || (v < acc_min(w, sgn));
  endfunction

  // Clamped when sat is set; otherwise returned untouched and the caller keeps the low w bits.
  function automatic calc_t acc_fit(calc_t v, int unsigned w, bit sgn, bit sat);
    if (sat && (v > acc_max(w, sgn))) return acc_max(w, sgn);
    if (sat && (v < acc_min(w, sgn))) return acc_min(w, sgn);
    return v;
  endfunction

  function automatic int unsigned lane_lsb(int unsigned idx, int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/pe_lane_dot.sv
// Combinational LANES-way multiply and adder tree; zero latency, no flow control.
// p_o is the exact beat dot product, with p_sign_o as its extra sign bit (always 0 when unsigned).
module pe_lane_dot
  import pe_pkg::*;
#(
  parameter int D_W    = 8,
  parameter int LANES  = 2,
  parameter int SIGNED = 0,
  localparam int P_W   = 2 * D_W + $clog2(LANES)
) (
  input  logic [LANES*D_W-1:0] a_i,
  input  logic [LANES*D_W-1:0] b_i,
  output logic [P_W-1:0]       p_o,
  output logic                 p_sign_o
);

  logic signed [P_W:0] a_x;
  logic signed [P_W:0] b_x;
  logic signed [P_W:0] sum;
  logic [D_W-1:0]      a_l;
  logic [D_W-1:0]      b_l;

  // Operands are widened to the result width first, so the truncated product is exact.
  always_comb begin
    sum = '0;
    a_x = '0;
    b_x = '0;
    a_l = '0;
    b_l = '0;
    for (int i = 0; i < LANES; i++) begin
      a_l = a_i[lane_lsb(i, D_W) +: D_W];
      b_l = b_i[lane_lsb(i, D_W) +: D_W];
      a_x = {{(P_W + 1 - D_W){(SIGNED != 0) & a_l[D_W-1]}}, a_l};
      b_x = {{(P_W + 1 - D_W){(SIGNED != 0) & b_l[D_W-1]}}, b_l};
      sum = sum + a_x * b_x;
    end
  end

  assign p_o      = sum[P_W-1:0];
  assign p_sign_o = sum[P_W];

endmodule

// File: rtl/pe_vec.sv
// Systolic PE tile: 1-cycle operand pass-through plus a LANES-wide dot-product accumulator dumped on init.
// The one-entry sum holder waits on sum_ready; a dump into an unaccepted holder overwrites it and sets sticky drop_err.
module pe_vec
  import pe_pkg::*;
#(
  parameter int D_W      = 8,
  parameter int D_W_ACC  = 32,
  parameter int LANES    = 2,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 init,
  input  logic [LANES*D_W-1:0] in_a,
  input  logic [LANES*D_W-1:0] in_b,
  output logic [LANES*D_W-1:0] out_a,
  output logic [LANES*D_W-1:0] out_b,
  output logic                 out_valid,
  output logic [D_W_ACC-1:0]   out_sum,
  output logic                 out_ovf,
  output logic                 valid_D,
  input  logic                 sum_ready,
  output logic                 drop_err
);

  localparam int P_W = 2 * D_W + $clog2(LANES);
  localparam bit SGN = (SIGNED != 0);
  localparam bit SAT = (SATURATE != 0);

  if ((LANES < 1) || (D_W_ACC < P_W) || (D_W_ACC > CALC_W - 2)) begin : g_cfg_check
    $error("pe_vec: D_W_ACC must cover 2*D_W + clog2(LANES) and stay within the calc width");
  end

  logic [P_W-1:0] p;
  logic           p_sign;

  pe_lane_dot #(
    .D_W   (D_W),
    .LANES (LANES),
    .SIGNED(SIGNED)
  ) u_dot (
    .a_i     (in_a),
    .b_i     (in_b),
    .p_o     (p),
    .p_sign_o(p_sign)
  );

  logic [LANES*D_W-1:0]    a_q, b_q;
  logic                    vld_q;
  logic [D_W_ACC-1:0]      acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic [D_W_ACC-1:0]      hold_sum_q, hold_sum_d;
  logic                    hold_ovf_q, hold_ovf_d;
  logic                    hold_vld_q, hold_vld_d;
  logic                    drop_q, drop_d;
  calc_t                   p_x, base_x, sum_x, fit_x;
  logic                    beat_ovf;
  logic [CALC_W-D_W_ACC-1:0] unused_fit_hi;

  // On init the beat starts a fresh accumulation, so the running sum is dropped from the adder.
  always_comb begin
    p_x      = calc_t'({{(CALC_W - P_W){p_sign}}, p});
    base_x   = init ? '0 : calc_t'({{(CALC_W - D_W_ACC){SGN & acc_q[D_W_ACC-1]}}, acc_q});
    sum_x    = base_x + p_x;
    beat_ovf = acc_ovf(sum_x, D_W_ACC, SGN);
    fit_x    = acc_fit(sum_x, D_W_ACC, SGN, SAT);
  end

  assign unused_fit_hi = fit_x[CALC_W-1:D_W_ACC];

  always_comb begin
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    hold_sum_d = hold_sum_q;
    hold_ovf_d = hold_ovf_q;
    hold_vld_d = hold_vld_q;
    drop_d     = drop_q;
    if (in_valid) begin
      acc_d = fit_x[D_W_ACC-1:0];
      ovf_d = (ovf_q & ~init) | beat_ovf;
    end else if (init) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
    if (init) begin
      hold_sum_d = acc_q;
      hold_ovf_d = ovf_q;
      hold_vld_d = 1'b1;
      if (hold_vld_q && !sum_ready) drop_d = 1'b1;
    end else if (hold_vld_q && sum_ready) begin
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q        <= '0;
      b_q        <= '0;
      vld_q      <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      hold_sum_q <= '0;
      hold_ovf_q <= 1'b0;
      hold_vld_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      a_q        <= in_a;
      b_q        <= in_b;
      vld_q      <= in_valid;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      hold_sum_q <= hold_sum_d;
      hold_ovf_q <= hold_ovf_d;
      hold_vld_q <= hold_vld_d;
      drop_q     <= drop_d;
    end
  end

  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_valid = vld_q;
  assign out_sum   = hold_sum_q;
  assign out_ovf   = hold_ovf_q;
  assign valid_D   = hold_vld_q;
  assign drop_err  = drop_q;

endmodule

// File: tb/tb_pe_vec.sv
// Bench for pe_vec: four configurations share one stimulus stream and are checked against an integer model.
// Configs: 0 unsigned/17b/sat, 1 signed/17b/sat, 2 unsigned/18b/sat, 3 unsigned/18b/wrap.
module tb_pe_vec;

  logic        clk = 1'b0;
  logic        rst, in_valid, init, sum_ready;
  logic [15:0] in_a, in_b;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  logic [17:0] sum_o  [4];
  logic        ovf_o  [4];
  logic        vd_o   [4];
  logic        drop_o [4];
  logic        ov_o   [4];
  logic [15:0] oa_o   [4];
  logic [15:0] ob_o   [4];

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int W = (k < 2) ? 17 : 18;
    logic [W-1:0] s;
    pe_vec #(
      .D_W(8), .D_W_ACC(W), .LANES(2),
      .SIGNED((k == 1) ? 1 : 0), .SATURATE((k == 3) ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .init(init),
      .in_a(in_a), .in_b(in_b), .out_a(oa_o[k]), .out_b(ob_o[k]),
      .out_valid(ov_o[k]), .out_sum(s), .out_ovf(ovf_o[k]),
      .valid_D(vd_o[k]), .sum_ready(sum_ready), .drop_err(drop_o[k])
    );
    assign sum_o[k] = 18'(s);
  end

  int cfg_w  [4] = '{17, 17, 18, 18};
  bit cfg_sg [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  bit cfg_st [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  // Reference state: accumulation as plain integers, holder as a value plus flags.
  longint      m_acc  [4];
  bit          m_ovf  [4];
  longint      m_hsum [4];
  bit          m_hovf [4];
  bit          m_hvld [4];
  bit          m_drop [4];
  logic [15:0] m_a, m_b;
  logic        m_v;

  function automatic longint lane_v(logic [15:0] v, int i, bit sg);
    logic [7:0] x;
    x = v[i*8 +: 8];
    return sg ? longint'($signed(x)) : longint'(x);
  endfunction

  function automatic longint beat(int k, logic [15:0] a, logic [15:0] b);
    return lane_v(a, 0, cfg_sg[k]) * lane_v(b, 0, cfg_sg[k]) +
           lane_v(a, 1, cfg_sg[k]) * lane_v(b, 1, cfg_sg[k]);
  endfunction

  function automatic longint rmax(int k);
    return cfg_sg[k] ? (longint'(1) << (cfg_w[k] - 1)) - 1 : (longint'(1) << cfg_w[k]) - 1;
  endfunction

  function automatic longint rmin(int k);
    return cfg_sg[k] ? -(longint'(1) << (cfg_w[k] - 1)) : longint'(0);
  endfunction

  function automatic bit out_of_range(int k, longint v);
    return (v > rmax(k)) || (v < rmin(k));
  endfunction

  function automatic longint fitv(int k, longint v);
    longint md, r;
    md = longint'(1) << cfg_w[k];
    if (!out_of_range(k, v)) return v;
    if (cfg_st[k]) return (v > rmax(k)) ? rmax(k) : rmin(k);
    r = v % md;
    if (r < 0) r = r + md;
    if (cfg_sg[k] && (r > rmax(k))) r = r - md;
    return r;
  endfunction

  function automatic logic [17:0] enc(int k, longint v);
    longint md;
    md = longint'(1) << cfg_w[k];
    return 18'(v & (md - 1));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_acc[k] = 0; m_ovf[k] = 0; m_hsum[k] = 0;
      m_hovf[k] = 0; m_hvld[k] = 0; m_drop[k] = 0;
    end
    m_a = '0; m_b = '0; m_v = 1'b0;
  endtask

  // Advance the model with the inputs as sampled at the coming edge, then move to just after it.
  task automatic tick();
    longint p, s;
    for (int k = 0; k < 4; k++) begin
      p = beat(k, in_a, in_b);
      if (init) begin
        if (m_hvld[k] && !sum_ready) m_drop[k] = 1'b1;
        m_hsum[k] = m_acc[k];
        m_hovf[k] = m_ovf[k];
        m_hvld[k] = 1'b1;
        m_acc[k]  = in_valid ? fitv(k, p) : 0;
        m_ovf[k]  = in_valid ? out_of_range(k, p) : 1'b0;
      end else begin
        if (m_hvld[k] && sum_ready) m_hvld[k] = 1'b0;
        if (in_valid) begin
          s = m_acc[k] + p;
          m_ovf[k] = m_ovf[k] | out_of_range(k, s);
          m_acc[k] = fitv(k, s);
        end
      end
    end
    m_a = in_a; m_b = in_b; m_v = in_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; init = 1'b0; sum_ready = 1'b1; in_a = '0; in_b = '0;
    model_reset();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({sum_o[k], ovf_o[k], vd_o[k], drop_o[k]} !== 21'd0) begin
        errors++; $display("FAIL reset_hold[%0d]: got %h expected 0", k, {sum_o[k], ovf_o[k], vd_o[k], drop_o[k]});
      end
      checks++;
      if ({oa_o[k], ob_o[k], ov_o[k]} !== 33'd0) begin
        errors++; $display("FAIL reset_pass[%0d]: got %h expected 0", k, {oa_o[k], ob_o[k], ov_o[k]});
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_basic_unsigned();
    in_valid = 1'b1; in_a = {8'd2, 8'd1}; in_b = {8'd4, 8'd3};
    repeat (3) tick();
    in_a = '0; in_b = '0; init = 1'b1;
    checks++;
    if (vd_o[0] !== 1'b0) begin errors++; $display("FAIL basic_vld_pre: got %b expected 0", vd_o[0]); end
    tick();
    init = 1'b0; in_valid = 1'b0;
    checks++;
    if (sum_o[0] !== 18'd33) begin errors++; $display("FAIL basic_sum: got %0d expected 33", sum_o[0]); end
    checks++;
    if ({ovf_o[0], vd_o[0]} !== 2'b01) begin errors++; $display("FAIL basic_flags: got %b expected 01", {ovf_o[0], vd_o[0]}); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (sum_o[k] !== enc(k, m_hsum[k])) begin
        errors++; $display("FAIL basic_model[%0d]: got %h expected %h", k, sum_o[k], enc(k, m_hsum[k]));
      end
    end
    tick();
    checks++;
    if (vd_o[0] !== 1'b0) begin errors++; $display("FAIL basic_accept: got %b expected 0", vd_o[0]); end
  endtask

  task automatic test_signed();
    in_valid = 1'b1; in_a = {8'h02, 8'hFF}; in_b = {8'hFD, 8'h05};
    repeat (2) tick();
    in_valid = 1'b0; in_a = '0; in_b = '0; init = 1'b1;
    tick();
    init = 1'b0;
    checks++;
    if (sum_o[1] !== 18'h1FFEA) begin errors++; $display("FAIL signed_sum: got %h expected 1ffea", sum_o[1]); end
    checks++;
    if (ovf_o[1] !== 1'b0) begin errors++; $display("FAIL signed_ovf: got %b expected 0", ovf_o[1]); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({sum_o[k], ovf_o[k]} !== {enc(k, m_hsum[k]), m_hovf[k]}) begin
        errors++; $display("FAIL signed_model[%0d]: got %h/%b expected %h/%b", k, sum_o[k], ovf_o[k], enc(k, m_hsum[k]), m_hovf[k]);
      end
    end
    tick();
  endtask

  task automatic test_overflow();
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF;
    repeat (3) tick();
    in_valid = 1'b0; in_a = '0; in_b = '0; init = 1'b1;
    tick();
    init = 1'b0;
    checks++;
    if ({sum_o[2], ovf_o[2]} !== {18'h3FFFF, 1'b1}) begin
      errors++; $display("FAIL ovf_sat: got %h/%b expected 3ffff/1", sum_o[2], ovf_o[2]);
    end
    checks++;
    if ({sum_o[3], ovf_o[3]} !== {18'd128006, 1'b1}) begin
      errors++; $display("FAIL ovf_wrap: got %0d/%b expected 128006/1", sum_o[3], ovf_o[3]);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({sum_o[k], ovf_o[k]} !== {enc(k, m_hsum[k]), m_hovf[k]}) begin
        errors++; $display("FAIL ovf_model[%0d]: got %h/%b expected %h/%b", k, sum_o[k], ovf_o[k], enc(k, m_hsum[k]), m_hovf[k]);
      end
    end
    in_valid = 1'b1; in_a = {8'd2, 8'd1}; in_b = {8'd4, 8'd3};
    tick();
    in_valid = 1'b0; init = 1'b1;
    tick();
    init = 1'b0; in_a = '0; in_b = '0;
    for (int k = 2; k < 4; k++) begin
      checks++;
      if ({sum_o[k], ovf_o[k]} !== {18'd11, 1'b0}) begin
        errors++; $display("FAIL ovf_next[%0d]: got %0d/%b expected 11/0", k, sum_o[k], ovf_o[k]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    sum_ready = 1'b1; in_valid = 1'b1;
    in_a = {8'd2, 8'd1}; in_b = {8'd4, 8'd3};
    tick();
    in_a = {8'd10, 8'd20}; in_b = {8'd3, 8'd5}; init = 1'b1;
    tick();
    in_a = {8'd7, 8'd7}; in_b = {8'd1, 8'd1};
    tick();
    checks++;
    if ({sum_o[0], vd_o[0], drop_o[0]} !== {18'd130, 1'b1, 1'b0}) begin
      errors++; $display("FAIL b2b_load: got %0d/%b/%b expected 130/1/0", sum_o[0], vd_o[0], drop_o[0]);
    end
    in_valid = 1'b0;
    tick();
    tick();
    init = 1'b0;
    checks++;
    if ({sum_o[0], vd_o[0]} !== {18'd0, 1'b1}) begin
      errors++; $display("FAIL b2b_zero: got %0d/%b expected 0/1", sum_o[0], vd_o[0]);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({sum_o[k], vd_o[k], drop_o[k]} !== {enc(k, m_hsum[k]), m_hvld[k], m_drop[k]}) begin
        errors++; $display("FAIL b2b_model[%0d]: got %h/%b/%b expected %h/%b/%b", k, sum_o[k], vd_o[k], drop_o[k], enc(k, m_hsum[k]), m_hvld[k], m_drop[k]);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    sum_ready = 1'b0; in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom);
    tick();
    init = 1'b1;
    tick();
    init = 1'b0;
    checks++;
    if ({vd_o[0], drop_o[0]} !== 2'b10) begin errors++; $display("FAIL bp_first: got %b expected 10", {vd_o[0], drop_o[0]}); end
    in_a = 16'($urandom); in_b = 16'($urandom);
    repeat (2) tick();
    init = 1'b1;
    tick();
    init = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({vd_o[k], drop_o[k]} !== 2'b11) begin
        errors++; $display("FAIL bp_drop[%0d]: got %b expected 11", k, {vd_o[k], drop_o[k]});
      end
      checks++;
      if (sum_o[k] !== enc(k, m_hsum[k])) begin
        errors++; $display("FAIL bp_sum[%0d]: got %h expected %h", k, sum_o[k], enc(k, m_hsum[k]));
      end
    end
    tick();
    checks++;
    if (vd_o[0] !== 1'b1) begin errors++; $display("FAIL bp_hold: got %b expected 1", vd_o[0]); end
    sum_ready = 1'b1;
    tick();
    checks++;
    if ({vd_o[0], drop_o[0]} !== 2'b01) begin errors++; $display("FAIL bp_release: got %b expected 01", {vd_o[0], drop_o[0]}); end
  endtask

  task automatic test_passthrough();
    for (int n = 0; n < 20; n++) begin
      in_a = 16'($urandom); in_b = 16'($urandom); in_valid = 1'($urandom);
      init = ($urandom_range(0, 3) == 0); sum_ready = 1'($urandom);
      tick();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if ({oa_o[k], ob_o[k], ov_o[k]} !== {m_a, m_b, m_v}) begin
          errors++; $display("FAIL pass[%0d] cyc %0d: got %h expected %h", k, n, {oa_o[k], ob_o[k], ov_o[k]}, {m_a, m_b, m_v});
        end
        checks++;
        if ({sum_o[k], ovf_o[k], vd_o[k], drop_o[k]} !== {enc(k, m_hsum[k]), m_hovf[k], m_hvld[k], m_drop[k]}) begin
          errors++; $display("FAIL rand_hold[%0d] cyc %0d: got %h expected %h", k, n, {sum_o[k], ovf_o[k], vd_o[k], drop_o[k]}, {enc(k, m_hsum[k]), m_hovf[k], m_hvld[k], m_drop[k]});
        end
      end
    end
    init = 1'b0; in_valid = 1'b0; sum_ready = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_a = 16'($urandom) | 16'h0101; in_b = 16'($urandom) | 16'h0101;
    init = 1'b1; sum_ready = 1'b0;
    tick();
    init = 1'b0;
    repeat (2) tick();
    #3 rst = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({sum_o[k], ovf_o[k], vd_o[k], drop_o[k], oa_o[k], ob_o[k], ov_o[k]} !== 54'd0) begin
        errors++; $display("FAIL async_clear[%0d]: got %h expected 0", k, {sum_o[k], ovf_o[k], vd_o[k], drop_o[k], oa_o[k], ob_o[k], ov_o[k]});
      end
    end
    in_valid = 1'b0; in_a = '0; in_b = '0; sum_ready = 1'b1;
    #2 rst = 1'b1;
    in_valid = 1'b1; in_a = 16'h0101; in_b = 16'h0101;
    repeat (2) tick();
    in_valid = 1'b0; init = 1'b1;
    tick();
    init = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({sum_o[k], ovf_o[k], vd_o[k], drop_o[k]} !== {18'd4, 1'b0, 1'b1, 1'b0}) begin
        errors++; $display("FAIL async_after[%0d]: got %0d/%b/%b/%b expected 4/0/1/0", k, sum_o[k], ovf_o[k], vd_o[k], drop_o[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_unsigned();
    test_signed();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_passthrough();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
